// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches ID operands and control, decodes the ALU
// control code, forwards from EX/MEM and MEM/WB, and inserts load-use bubbles.
// Optional feature macro: ID_EX_BUBBLE_COUNT_EN (adds the bubbleCount output).
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idValid,
    input  logic [WIDTH-1:0] idReadData1,
    input  logic [WIDTH-1:0] idReadData2,
    input  logic [WIDTH-1:0] idSignExt,
    input  logic [REGW-1:0]  idRs,
    input  logic [REGW-1:0]  idRt,
    input  logic [REGW-1:0]  idRd,
    input  logic [1:0]       idAluOp,
    input  logic [5:0]       idFunct,
    input  logic             idUsesRt,
    input  logic             idAluSrc,
    input  logic             idRegDst,
    input  logic             idRegWrite,
    input  logic             idMemRead,
    input  logic             idMemWrite,
    input  logic             idMemToReg,
    input  logic             idBranch,
    input  logic             stall,
    input  logic             flush,
    input  logic             exMemRegWrite,
    input  logic [REGW-1:0]  exMemRd,
    input  logic [WIDTH-1:0] exMemAluRes,
    input  logic             memWbRegWrite,
    input  logic [REGW-1:0]  memWbRd,
    input  logic [WIDTH-1:0] memWbData,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic [3:0]       aluCtr,
    output logic [WIDTH-1:0] storeData,
    output logic [REGW-1:0]  writeReg,
    output logic             exValid,
    output logic             exRegWrite,
    output logic             exMemRead,
    output logic             exMemWrite,
    output logic             exMemToReg,
    output logic             exBranch,
`ifdef ID_EX_BUBBLE_COUNT_EN
    output logic [31:0]      bubbleCount,
`endif
    output logic             hazardStall
);

    logic             valid_reg;
    logic             regwrite_reg;
    logic             memread_reg;
    logic             memwrite_reg;
    logic             memtoreg_reg;
    logic             branch_reg;
    logic             alusrc_reg;
    logic [WIDTH-1:0] data1_reg;
    logic [WIDTH-1:0] data2_reg;
    logic [WIDTH-1:0] signext_reg;
    logic [REGW-1:0]  rs_reg;
    logic [REGW-1:0]  rt_reg;
    logic [REGW-1:0]  writereg_reg;
    logic [3:0]       aluctr_reg;

    logic [3:0]       aluctr_next;
    logic [REGW-1:0]  writereg_next;
    logic             hazard_stall;

    always_comb begin
        aluctr_next = 4'b1111;
        case (idAluOp)
            2'b00: aluctr_next = 4'b0010;
            2'b01: aluctr_next = 4'b0110;
            2'b10: begin
                case (idFunct)
                    6'b100000: aluctr_next = 4'b0010;
                    6'b100010: aluctr_next = 4'b0110;
                    6'b100100: aluctr_next = 4'b0000;
                    6'b100101: aluctr_next = 4'b0001;
                    6'b101010: aluctr_next = 4'b0111;
                    6'b100111: aluctr_next = 4'b1100;
                    default:   aluctr_next = 4'b1111;
                endcase
            end
            default: aluctr_next = 4'b1111;
        endcase
    end

    assign writereg_next = idRegDst ? idRd : idRt;

    // Load in EX whose target is read by the instruction waiting in ID.
    assign hazard_stall = !flush && valid_reg && memread_reg &&
                          (rt_reg != '0) && idValid &&
                          ((rt_reg == idRs) || (idUsesRt && (rt_reg == idRt)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            branch_reg   <= 1'b0;
            alusrc_reg   <= 1'b0;
            data1_reg    <= '0;
            data2_reg    <= '0;
            signext_reg  <= '0;
            rs_reg       <= '0;
            rt_reg       <= '0;
            writereg_reg <= '0;
            aluctr_reg   <= 4'b1111;
        end else if (flush || hazard_stall) begin
            // Data fields are left as they are; only control is killed.
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            memread_reg  <= 1'b0;
            memwrite_reg <= 1'b0;
            memtoreg_reg <= 1'b0;
            branch_reg   <= 1'b0;
            alusrc_reg   <= 1'b0;
            aluctr_reg   <= 4'b1111;
        end else if (!stall) begin
            valid_reg    <= idValid;
            regwrite_reg <= idRegWrite;
            memread_reg  <= idMemRead;
            memwrite_reg <= idMemWrite;
            memtoreg_reg <= idMemToReg;
            branch_reg   <= idBranch;
            alusrc_reg   <= idAluSrc;
            data1_reg    <= idReadData1;
            data2_reg    <= idReadData2;
            signext_reg  <= idSignExt;
            rs_reg       <= idRs;
            rt_reg       <= idRt;
            writereg_reg <= writereg_next;
            aluctr_reg   <= aluctr_next;
        end
    end

    logic [REGW-1:0]  fwd_idx [2];
    logic [WIDTH-1:0] fwd_base [2];
    logic [WIDTH-1:0] fwd_val [2];

    assign fwd_idx[0]  = rs_reg;
    assign fwd_idx[1]  = rt_reg;
    assign fwd_base[0] = data1_reg;
    assign fwd_base[1] = data2_reg;

    // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            always_comb begin
                if (exMemRegWrite && (exMemRd != '0) && (exMemRd == fwd_idx[gi]))
                    fwd_val[gi] = exMemAluRes;
                else if (memWbRegWrite && (memWbRd != '0) && (memWbRd == fwd_idx[gi]))
                    fwd_val[gi] = memWbData;
                else
                    fwd_val[gi] = fwd_base[gi];
            end
        end
    endgenerate

    assign input1      = fwd_val[0];
    assign input2      = alusrc_reg ? signext_reg : fwd_val[1];
    assign storeData   = fwd_val[1];
    assign aluCtr      = aluctr_reg;
    assign writeReg    = writereg_reg;
    assign exValid     = valid_reg;
    assign exRegWrite  = regwrite_reg;
    assign exMemRead   = memread_reg;
    assign exMemWrite  = memwrite_reg;
    assign exMemToReg  = memtoreg_reg;
    assign exBranch    = branch_reg;
    assign hazardStall = hazard_stall;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bubble_count_reg <= '0;
        else if ((flush || hazard_stall) && (bubble_count_reg != 32'hFFFF_FFFF))
            bubble_count_reg <= bubble_count_reg + 32'd1;
    end

    assign bubbleCount = bubble_count_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues expected values tagged with
// the cycle they apply to; a negedge monitor pops and compares them.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        idValid, idUsesRt, idAluSrc, idRegDst, idRegWrite;
    logic        idMemRead, idMemWrite, idMemToReg, idBranch;
    logic [31:0] idReadData1, idReadData2, idSignExt;
    logic [4:0]  idRs, idRt, idRd;
    logic [1:0]  idAluOp;
    logic [5:0]  idFunct;
    logic        stall, flush;
    logic        exMemRegWrite, memWbRegWrite;
    logic [4:0]  exMemRd, memWbRd;
    logic [31:0] exMemAluRes, memWbData;
    logic [31:0] input1, input2, storeData;
    logic [3:0]  aluCtr;
    logic [4:0]  writeReg;
    logic        exValid, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch;
    logic        hazardStall;
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubbleCount;
`endif

    id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
        .clk(clk), .reset(reset), .idValid(idValid),
        .idReadData1(idReadData1), .idReadData2(idReadData2), .idSignExt(idSignExt),
        .idRs(idRs), .idRt(idRt), .idRd(idRd), .idAluOp(idAluOp), .idFunct(idFunct),
        .idUsesRt(idUsesRt), .idAluSrc(idAluSrc), .idRegDst(idRegDst),
        .idRegWrite(idRegWrite), .idMemRead(idMemRead), .idMemWrite(idMemWrite),
        .idMemToReg(idMemToReg), .idBranch(idBranch), .stall(stall), .flush(flush),
        .exMemRegWrite(exMemRegWrite), .exMemRd(exMemRd), .exMemAluRes(exMemAluRes),
        .memWbRegWrite(memWbRegWrite), .memWbRd(memWbRd), .memWbData(memWbData),
        .input1(input1), .input2(input2), .aluCtr(aluCtr), .storeData(storeData),
        .writeReg(writeReg), .exValid(exValid), .exRegWrite(exRegWrite),
        .exMemRead(exMemRead), .exMemWrite(exMemWrite), .exMemToReg(exMemToReg),
        .exBranch(exBranch),
`ifdef ID_EX_BUBBLE_COUNT_EN
        .bubbleCount(bubbleCount),
`endif
        .hazardStall(hazardStall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          at;
        int          sel;
        logic [31:0] exp;
        int          tag;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   tag_cnt = 0;

    localparam int S_IN1 = 0, S_IN2 = 1, S_ALU = 2, S_ST = 3, S_WR = 4;
    localparam int S_VAL = 5, S_HAZ = 6, S_MRD = 7, S_BC = 8, S_RW = 9;

    function automatic string sel_name(int s);
        case (s)
            S_IN1: return "input1";
            S_IN2: return "input2";
            S_ALU: return "aluCtr";
            S_ST:  return "storeData";
            S_WR:  return "writeReg";
            S_VAL: return "exValid";
            S_HAZ: return "hazardStall";
            S_MRD: return "exMemRead";
            S_BC:  return "bubbleCount";
            default: return "exRegWrite";
        endcase
    endfunction

    function automatic logic [31:0] get(int s);
        case (s)
            S_IN1: return input1;
            S_IN2: return input2;
            S_ALU: return {28'd0, aluCtr};
            S_ST:  return storeData;
            S_WR:  return {27'd0, writeReg};
            S_VAL: return {31'd0, exValid};
            S_HAZ: return {31'd0, hazardStall};
            S_MRD: return {31'd0, exMemRead};
`ifdef ID_EX_BUBBLE_COUNT_EN
            S_BC:  return bubbleCount;
`endif
            default: return {31'd0, exRegWrite};
        endcase
    endfunction

    task automatic expect_at(input int at, input int sel, input logic [31:0] v);
        exp_t e;
        e.at = at; e.sel = sel; e.exp = v; e.tag = tag_cnt;
        tag_cnt++;
        q.push_back(e);
    endtask

    // Monitor: every expectation due this cycle is compared at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            checks++;
            act = get(e.sel);
            if (e.at < cyc) begin
                errors++;
                $display("FAIL #%0d %s: check missed its cycle %0d (now %0d)", e.tag, sel_name(e.sel), e.at, cyc);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL #%0d %s: got %h, expected %h", e.tag, sel_name(e.sel), act, e.exp);
            end else begin
                $display("ok   #%0d cyc %0d %s = %h", e.tag, cyc, sel_name(e.sel), act);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        idValid = 0; idUsesRt = 0; idAluSrc = 0; idRegDst = 0; idRegWrite = 0;
        idMemRead = 0; idMemWrite = 0; idMemToReg = 0; idBranch = 0;
        idReadData1 = 0; idReadData2 = 0; idSignExt = 0;
        idRs = 0; idRt = 0; idRd = 0; idAluOp = 2'b00; idFunct = 0;
    endtask

    task automatic load_lw8();
        clear_id();
        idValid = 1; idMemRead = 1; idRegWrite = 1; idAluSrc = 1; idMemToReg = 1;
        idRt = 5'd8; idSignExt = 32'd4;
    endtask

    logic [1:0]  dec_op [9]  = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0]  dec_fn [9]  = '{6'b100010, 6'b100000, 6'b100000, 6'b100000, 6'b100010,
                                6'b100100, 6'b100101, 6'b100111, 6'b000000};
    logic [3:0]  dec_exp [9] = '{4'b0010, 4'b0110, 4'b1111, 4'b0010, 4'b0110,
                                4'b0000, 4'b0001, 4'b1100, 4'b1111};

    initial begin
        clear_id();
        stall = 0; flush = 0;
        exMemRegWrite = 0; exMemRd = 0; exMemAluRes = 0;
        memWbRegWrite = 0; memWbRd = 0; memWbData = 0;
        step();
        // Reset state
        expect_at(cyc, S_ALU, 32'hF);
        expect_at(cyc, S_VAL, 0);
        expect_at(cyc, S_IN1, 0);
        expect_at(cyc, S_HAZ, 0);
        step();
        reset = 0;
        step();

        // slt R-type load, then hold under stall, then reset mid-stall
        idValid = 1; idAluOp = 2'b10; idFunct = 6'b101010;
        idReadData1 = 5; idReadData2 = 9; idRs = 1; idRt = 2; idRd = 3;
        idRegDst = 1; idRegWrite = 1;
        expect_at(cyc + 1, S_ALU, 4'b0111);
        expect_at(cyc + 1, S_IN1, 5);
        expect_at(cyc + 1, S_IN2, 9);
        expect_at(cyc + 1, S_VAL, 1);
        expect_at(cyc + 1, S_WR, 3);
        step();
        clear_id();
        stall = 1;
        step();
        expect_at(cyc, S_VAL, 1);
        expect_at(cyc, S_IN1, 5);
        expect_at(cyc, S_ALU, 4'b0111);
        step();
        reset = 1;
        expect_at(cyc, S_VAL, 0);
        expect_at(cyc, S_ALU, 32'hF);
        expect_at(cyc, S_IN1, 0);
        expect_at(cyc, S_IN2, 0);
        expect_at(cyc, S_WR, 0);
        expect_at(cyc, S_HAZ, 0);
        step();
        reset = 0; stall = 0;

        // ALU control decode table
        for (int i = 0; i < 9; i++) begin
            clear_id();
            idValid = 1; idAluOp = dec_op[i]; idFunct = dec_fn[i];
            expect_at(cyc + 1, S_ALU, {28'd0, dec_exp[i]});
            step();
        end

        // Load-use: lw $8 in EX, add $9,$8,$2 in ID
        load_lw8();
        step();
        clear_id();
        idValid = 1; idRs = 5'd8; idRt = 5'd2; idRd = 5'd9; idUsesRt = 1;
        idAluOp = 2'b10; idFunct = 6'b100000; idRegDst = 1; idRegWrite = 1;
        idReadData1 = 32'h100; idReadData2 = 32'h7;
        expect_at(cyc, S_HAZ, 1);
        step();
        expect_at(cyc, S_VAL, 0);
        expect_at(cyc, S_ALU, 32'hF);
        expect_at(cyc, S_MRD, 0);
        expect_at(cyc, S_HAZ, 0);
        step();
        expect_at(cyc, S_VAL, 1);
        expect_at(cyc, S_ALU, 4'b0010);
        expect_at(cyc, S_WR, 9);
        expect_at(cyc, S_IN1, 32'h100);
        expect_at(cyc, S_RW, 1);

        // rt match but rt is not a source: no hazard
        load_lw8();
        step();
        clear_id();
        idValid = 1; idRs = 5'd1; idRt = 5'd8; idUsesRt = 0;
        expect_at(cyc, S_HAZ, 0);
        step();

        // Forwarding priority on operand A, then operand B
        clear_id();
        idValid = 1; idRs = 5'd3; idRt = 5'd4; idReadData1 = 32'hAA; idReadData2 = 32'hBB;
        step();
        clear_id();
        stall = 1;
        exMemRegWrite = 1; exMemRd = 3; exMemAluRes = 32'h11;
        memWbRegWrite = 1; memWbRd = 3; memWbData = 32'h22;
        expect_at(cyc, S_IN1, 32'h11);
        expect_at(cyc, S_ST, 32'hBB);
        step();
        exMemRegWrite = 0;
        expect_at(cyc, S_IN1, 32'h22);
        step();
        memWbRegWrite = 0;
        expect_at(cyc, S_IN1, 32'hAA);
        step();
        exMemRegWrite = 1; exMemRd = 4;
        expect_at(cyc, S_ST, 32'h11);
        expect_at(cyc, S_IN2, 32'h11);
        expect_at(cyc, S_IN1, 32'hAA);
        step();

        // Register 0 never forwarded; immediate selected for input2
        stall = 0;
        exMemRd = 0; exMemAluRes = 32'h99;
        memWbRegWrite = 1; memWbRd = 0; memWbData = 32'h77;
        clear_id();
        idValid = 1; idRs = 0; idRt = 0; idReadData1 = 32'h66; idReadData2 = 32'h55;
        idAluSrc = 1; idSignExt = 32'hFFFF_FFFC;
        expect_at(cyc + 1, S_ST, 32'h55);
        expect_at(cyc + 1, S_IN1, 32'h66);
        expect_at(cyc + 1, S_IN2, 32'hFFFF_FFFC);
        step();
        exMemRegWrite = 0; memWbRegWrite = 0;

        // stall + flush together clears; flush masks the hazard
        load_lw8();
        step();
        clear_id();
        idValid = 1; idRs = 5'd8;
        stall = 1; flush = 1;
        expect_at(cyc, S_HAZ, 0);
        expect_at(cyc + 1, S_VAL, 0);
        expect_at(cyc + 1, S_ALU, 32'hF);
        expect_at(cyc + 1, S_MRD, 0);
        step();
        stall = 0; flush = 0;
        clear_id();
        step();

`ifdef ID_EX_BUBBLE_COUNT_EN
        reset = 1;
        step();
        reset = 0;
        expect_at(cyc, S_BC, 0);
        flush = 1;
        step(); step(); step();
        flush = 0;
        for (int k = 0; k < 2; k++) begin
            load_lw8();
            step();
            clear_id();
            idValid = 1; idRs = 5'd8;
            step();
        end
        clear_id();
        expect_at(cyc, S_BC, 5);
        step();
`endif

        step();
        step();
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: %0d expectations never checked, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
